// File: rtl/n2r_chunk_dispatcher_i.sv
// n2r_chunk_dispatcher_i
//   Buffers block-ordered chunk words from the row-to-block converter in a
//   small FIFO and hands them to the MAC core array under valid/ready,
//   tagging each word with the row-major block index of core 0's block and
//   first/last-of-matrix markers. Words offered while full are dropped and
//   recorded in a sticky error flag.
//
// Ports
//   clk, rst_n         : rising-edge clock, synchronous active-low reset
//   in_valid/in_chunk  : word from the converter (no backpressure upstream)
//   in_ready           : FIFO has room
//   out_valid/out_ready: handshake towards the core array
//   out_chunk          : buffered word, bit-identical to the input
//   out_blk_idx        : word_count * NUM_CORES
//   out_first/out_last : word is first / last of a matrix
//   fifo_level         : occupied entries
//   drop_err           : sticky, a word was offered while full
module n2r_chunk_dispatcher_i #(
  parameter int WIDTH      = 16,
  parameter int BLOCK_SIZE = 2,
  parameter int CHUNK_SIZE = 4,
  parameter int ROW        = 8,
  parameter int COL        = 6,
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int OUT_WIDTH = WIDTH * CHUNK_SIZE * NUM_CORES,
  localparam int WORDS     = (ROW / BLOCK_SIZE) * (COL / BLOCK_SIZE) / NUM_CORES,
  localparam int IDXW      = (WORDS * NUM_CORES > 1) ? $clog2(WORDS * NUM_CORES) : 1,
  localparam int LVLW      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [OUT_WIDTH-1:0] in_chunk,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_chunk,
  output logic [IDXW-1:0]      out_blk_idx,
  output logic                 out_first,
  output logic                 out_last,
  output logic [LVLW-1:0]      fifo_level,
  output logic                 drop_err
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0] level_q,  level_d;
  logic [CNTW-1:0] cnt_q,    cnt_d;
  logic            drop_q,   drop_d;
  logic            push, pop;

  // Handshake flags are gated by rst_n so neither side sees a live FIFO
  // while reset is held, even before the first reset edge has cleared state.
  assign in_ready    = rst_n && (level_q < LVLW'(FIFO_DEPTH));
  assign out_valid   = rst_n && (level_q != '0);
  assign out_chunk   = mem_q[rd_ptr_q];
  assign out_first   = (cnt_q == '0);
  assign out_last    = (cnt_q == CNTW'(WORDS - 1));
  assign out_blk_idx = IDXW'(cnt_q) * IDXW'(NUM_CORES);
  assign fifo_level  = level_q;
  assign drop_err    = drop_q;

  always_comb begin
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;

    // FIFO_DEPTH is a power of two, so pointers wrap by natural overflow.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTRW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
      cnt_d    = (cnt_q == CNTW'(WORDS - 1)) ? '0 : cnt_q + CNTW'(1);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVLW'(1);
      2'b01:   level_d = level_q - LVLW'(1);
      default: level_d = level_q;
    endcase

    if (in_valid && !in_ready) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: contents are only observed when level_q != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_chunk;
    end
  end

endmodule

// File: tb/tb_n2r_chunk_dispatcher_i.sv
// Testbench for n2r_chunk_dispatcher_i: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based reference model.
module tb_n2r_chunk_dispatcher_i;

  localparam int DEPTH = 4;
  localparam int WORDS = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_chunk;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_chunk;
  logic [3:0]   out_blk_idx;
  logic         out_first;
  logic         out_last;
  logic [2:0]   fifo_level;
  logic         drop_err;

  n2r_chunk_dispatcher_i #(
    .WIDTH(16), .BLOCK_SIZE(2), .CHUNK_SIZE(4), .ROW(8), .COL(6),
    .NUM_CORES(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_chunk(in_chunk), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_chunk(out_chunk),
    .out_blk_idx(out_blk_idx), .out_first(out_first), .out_last(out_last),
    .fifo_level(fifo_level), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue, popped-word counter, sticky flag.
  logic [127:0] mq[$];
  int  mcnt  = 0;
  bit  mdrop = 0;
  bit  init  = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mcnt  = 0;
      mdrop = 0;
      init  = 1;
    end else if (init) begin
      bit p, o;
      p = in_valid && (mq.size() < DEPTH);
      o = out_ready && (mq.size() != 0);
      if (in_valid && !p) mdrop = 1;
      if (o) begin
        void'(mq.pop_front());
        mcnt = (mcnt + 1) % WORDS;
      end
      if (p) mq.push_back(in_chunk);
    end
  end

  // Log of words the DUT hands over, for the directed literal checks.
  logic [127:0] pd[$];
  logic [3:0]   pi[$];
  bit           pf[$];
  bit           pl[$];
  int           maxlvl = 0;

  always @(negedge clk) begin
    if (init) begin
      bit ev;
      ev = rst_n && (mq.size() != 0);
      check("in_ready",   {127'd0, in_ready},  {127'd0, rst_n && (mq.size() < DEPTH)});
      check("out_valid",  {127'd0, out_valid}, {127'd0, ev});
      check("fifo_level", {125'd0, fifo_level}, 128'(mq.size()));
      check("drop_err",   {127'd0, drop_err},  {127'd0, mdrop});
      if (ev) begin
        check("out_chunk", out_chunk, mq[0]);
        check("out_blk_idx", {124'd0, out_blk_idx}, 128'(mcnt * 2));
        check("out_first", {127'd0, out_first}, {127'd0, mcnt == 0});
        check("out_last",  {127'd0, out_last},  {127'd0, mcnt == WORDS - 1});
      end
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
      if (rst_n && out_valid && out_ready) begin
        pd.push_back(out_chunk);
        pi.push_back(out_blk_idx);
        pf.push_back(out_first);
        pl.push_back(out_last);
      end
    end
  end

  function automatic logic [127:0] mkw(input logic [15:0] t);
    return {8{t}};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    pd.delete(); pi.delete(); pf.delete(); pl.delete();
    maxlvl = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  int idx6  [6]  = '{0, 2, 4, 6, 8, 10};
  int idx12 [12] = '{0, 2, 4, 6, 8, 10, 0, 2, 4, 6, 8, 10};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_chunk = '0;
    #1;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    check("reset_level", {125'd0, fifo_level}, 128'd0);
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);

    // Streaming six words with out_ready held high.
    clear_log();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_chunk = mkw(16'h1000 + 16'(i));
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    check("t1_count", 128'(pd.size()), 128'd6);
    for (int i = 0; i < 6 && i < pd.size(); i++) begin
      check("t1_data", pd[i], mkw(16'h1000 + 16'(i)));
      check("t1_idx", {124'd0, pi[i]}, 128'(idx6[i]));
    end
    if (pd.size() == 6) begin
      check("t1_first_w0", {127'd0, pf[0]}, 128'd1);
      check("t1_last_w5", {127'd0, pl[5]}, 128'd1);
      check("t1_last_w4", {127'd0, pl[4]}, 128'd0);
    end
    check("t1_maxlvl", 128'(maxlvl), 128'd1);
    check("t1_drop", {127'd0, drop_err}, 128'd0);

    // Fill with out_ready low, then offer one word too many.
    clear_log();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_chunk = mkw(16'h2000 + 16'(i));
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    check("t2_level_full", {125'd0, fifo_level}, 128'd4);
    check("t2_in_ready", {127'd0, in_ready}, 128'd0);
    check("t2_hold_w0", out_chunk, mkw(16'h2000));
    in_valid = 1'b1; in_chunk = mkw(16'h2004);
    cyc();
    in_valid = 1'b0;
    cyc();
    check("t3_drop_set", {127'd0, drop_err}, 128'd1);
    check("t3_level", {125'd0, fifo_level}, 128'd4);
    out_ready = 1'b1;
    repeat (6) cyc();
    check("t3_count", 128'(pd.size()), 128'd4);
    for (int i = 0; i < 4 && i < pd.size(); i++)
      check("t3_data", pd[i], mkw(16'h2000 + 16'(i)));
    check("t3_drop_sticky", {127'd0, drop_err}, 128'd1);

    // Simultaneous push and pop at level 2.
    do_reset();
    check("t4_drop_cleared", {127'd0, drop_err}, 128'd0);
    clear_log();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_chunk = mkw(16'h3000 + 16'(i));
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 2; i < 7; i++) begin
      in_valid = 1'b1; in_chunk = mkw(16'h3000 + 16'(i));
      cyc();
      check("t4_level2", {125'd0, fifo_level}, 128'd2);
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    check("t4_count", 128'(pd.size()), 128'd7);
    for (int i = 0; i < 7 && i < pd.size(); i++)
      check("t4_order", pd[i], mkw(16'h3000 + 16'(i)));

    // Two back-to-back matrices.
    do_reset();
    clear_log();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_chunk = mkw(16'h4000 + 16'(i));
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    check("t5_count", 128'(pd.size()), 128'd12);
    for (int i = 0; i < 12 && i < pd.size(); i++) begin
      check("t5_idx", {124'd0, pi[i]}, 128'(idx12[i]));
      check("t5_first", {127'd0, pf[i]}, {127'd0, (i == 0 || i == 6)});
      check("t5_last", {127'd0, pl[i]}, {127'd0, (i == 5 || i == 11)});
    end

    // Reset mid-operation discards buffered words.
    do_reset();
    clear_log();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_chunk = mkw(16'h5000 + 16'(i));
      cyc();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    check("t6_level_rst", {125'd0, fifo_level}, 128'd0);
    check("t6_in_ready_rst", {127'd0, in_ready}, 128'd0);
    check("t6_out_valid_rst", {127'd0, out_valid}, 128'd0);
    rst_n = 1'b1;
    cyc();
    check("t6_in_ready_after", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1; in_chunk = mkw(16'h5AAA); out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (2) cyc();
    check("t6_count", 128'(pd.size()), 128'd1);
    if (pd.size() >= 1) begin
      check("t6_data", pd[0], mkw(16'h5AAA));
      check("t6_first", {127'd0, pf[0]}, 128'd1);
      check("t6_idx", {124'd0, pi[0]}, 128'd0);
    end
    check("t6_drop", {127'd0, drop_err}, 128'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      in_chunk  = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) cyc();
    check("final_empty", {125'd0, fifo_level}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/n2r_chunk_dispatcher_i.md
# n2r_chunk_dispatcher_i

Downstream stage of `n2r_buffer_i` in the Multi MAC matrix-multiply path. Accepts the block-ordered chunk words that the row-to-block converter emits (NUM_CORES blocks of BLOCK_SIZE×BLOCK_SIZE elements per word) and buffers them in a small FIFO. It then hands them to the MAC core array under a valid/ready handshake, tagging each word with its block index and first/last-of-matrix markers. It decouples the converter's free-running output from MAC-core stalls, and it flags any word the converter pushes while the buffer is full.

## Interface
Parameters:
- `WIDTH`, 16: element width (Q8.8 fixed point; the dispatcher never interprets the value).
- `BLOCK_SIZE`, 2: block edge.
- `CHUNK_SIZE`, 4: elements per block; must equal BLOCK_SIZE*BLOCK_SIZE.
- `ROW`, 8: matrix rows; must be a multiple of BLOCK_SIZE.
- `COL`, 6: matrix columns; must be a multiple of BLOCK_SIZE.
- `NUM_CORES`, 2: blocks per word; (ROW/BLOCK_SIZE)*(COL/BLOCK_SIZE) must be a multiple of NUM_CORES.
- `FIFO_DEPTH`, 4: word entries; power of two, ≥2.
- Derived: `OUT_WIDTH` = WIDTH*CHUNK_SIZE*NUM_CORES; `WORDS` = (ROW/BLOCK_SIZE)*(COL/BLOCK_SIZE)/NUM_CORES; `IDXW` = max(1,clog2(WORDS*NUM_CORES)).

Ports:
- `clk` in 1: single clock for the whole block, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: `in_chunk` holds a word this cycle.
- `in_chunk` in OUT_WIDTH: word from `n2r_buffer_i.out_n2r_buffer`; core c's block occupies bits [(NUM_CORES-c)*CHUNK_SIZE*WIDTH-1 -: CHUNK_SIZE*WIDTH].
- `in_ready` out 1: FIFO can accept a word.
- `out_valid` out 1: `out_chunk` and its tags are valid.
- `out_ready` in 1: core array accepts the word.
- `out_chunk` out OUT_WIDTH: buffered word, bit-identical to the input.
- `out_blk_idx` out IDXW: row-major block index of core 0's block (= word_count*NUM_CORES).
- `out_first` out 1: word is word 0 of a matrix.
- `out_last` out 1: word is word WORDS-1 of a matrix.
- `fifo_level` out clog2(FIFO_DEPTH)+1: occupied entries.
- `drop_err` out 1: sticky; a word was offered while full.

## Operation
- Push: on `in_valid && in_ready`, write `in_chunk` at `wr_ptr`, then `wr_ptr++` (wraps at FIFO_DEPTH).
- Pop: on `out_valid && out_ready`, `rd_ptr++` and `word_cnt++`. `word_cnt` wraps from WORDS-1 to 0.
- `in_ready` = (`fifo_level` < FIFO_DEPTH). It is not dependent on `out_ready`: a full FIFO refuses a push even in a cycle with a pop.
- `out_valid` = (`fifo_level` != 0). `out_chunk` = mem[`rd_ptr`].
- While `out_valid` is high and `out_ready` is low, `out_chunk` and all tags are held stable.
- Tags come from `word_cnt` only:
  - `out_first` = (`word_cnt` == 0).
  - `out_last` = (`word_cnt` == WORDS-1).
  - `out_blk_idx` = `word_cnt`*NUM_CORES.
- Level update per cycle: push only → +1; pop only → −1; both → unchanged.
- A push and a pop may occur in the same cycle at any non-empty, non-full level.
- `drop_err` sets on `in_valid && !in_ready` and stays set until reset. The offered word is discarded; pointers and counters do not change.
- The upstream converter has no backpressure input. System integration sizes FIFO_DEPTH so that `drop_err` never fires in normal operation.

## Timing
- Reset (`rst_n` low at a rising edge) clears `wr_ptr`, `rd_ptr`, `fifo_level`, `word_cnt` and `drop_err`.
- While `rst_n` is low: `in_ready`=0 and `out_valid`=0. The next edge after `rst_n` rises gives `in_ready`=1.
- Reset mid-operation discards all buffered words. The first word after reset is tagged `out_first`=1 with `out_blk_idx`=0. FIFO memory contents are don't-care.
- Latency: a word pushed into an empty FIFO at edge N gives `out_valid`=1 after edge N, so it is poppable at edge N+1. There is no combinational path from `in_valid` to `out_valid`.
- Throughput: one word per cycle sustained when `out_ready` is held at 1.
- Full-FIFO boundary: at `fifo_level`==FIFO_DEPTH, `in_ready`=0. A pop at edge N gives `in_ready`=1 after edge N.
- `word_cnt` wrap: the pop of a word with `out_last`=1 makes the next word `out_first`=1. Back-to-back matrices need no idle cycle.

## Test plan
- Default parameters, feed 6 words (W0..W5) with `in_valid`=1 on consecutive cycles, `out_ready`=1 → 6 pops in order, each one cycle after its push. Tags:
  - W0: `out_blk_idx`=0, `out_first`=1.
  - W5: `out_blk_idx`=10, `out_last`=1.
  - `fifo_level` ≤ 1 throughout; `drop_err`=0.
- `out_ready`=0, push 4 words → `fifo_level`=4, `in_ready`=0, `out_chunk` held at W0. Then `out_ready`=1 → W0..W3 popped on 4 consecutive edges.
- Full FIFO, `out_ready`=0, offer a 5th word → `drop_err`=1 and stays 1. `fifo_level` stays 4. Drained output is W0..W3 only.
- `fifo_level`=2 with push and pop in the same cycle for 5 cycles → `fifo_level` stays 2, and output order matches input order.
- Push 12 words over two matrices → `out_first` on W0 and W6, `out_last` on W5 and W11, and `out_blk_idx` sequence 0,2,…,10,0,2,…,10.
- Push 3 words, assert `rst_n`=0 for one edge, then push W0' → `fifo_level`=0 during reset. W0' emerges with `out_first`=1 and `drop_err`=0.
